// File: rtl/rah_result_packetizer_if.sv
// ----------------------------------------------------------------------------
// rah_result_packetizer_if
// Bundles the result handshake (app core -> packetizer) and the encoder FIFO
// write port (packetizer -> rah_encoder slot) into one interface.
//
// Signals:
//   in_valid        result available (core -> packetizer)
//   in_ready        packetizer can accept a result
//   in_data         result payload, PAYLOAD_WIDTH bits
//   wr_fifo_full    encoder FIFO slot full; no write may occur while high
//   write_apps_data write strobe into the encoder FIFO
//   wr_data         word written when write_apps_data is high
//
// Modports:
//   master  the packetizer, which masters the encoder FIFO write port
//   slave   the surroundings: result source plus encoder FIFO
// ----------------------------------------------------------------------------
interface rah_result_packetizer_if #(
    parameter int unsigned RAH_PACKET_WIDTH = 48,
    parameter int unsigned PAYLOAD_WIDTH    = 288
) ();
    logic                        in_valid;
    logic                        in_ready;
    logic [PAYLOAD_WIDTH-1:0]    in_data;
    logic                        wr_fifo_full;
    logic                        write_apps_data;
    logic [RAH_PACKET_WIDTH-1:0] wr_data;

    modport master (
        input  in_valid,
        input  in_data,
        input  wr_fifo_full,
        output in_ready,
        output write_apps_data,
        output wr_data
    );

    modport slave (
        output in_valid,
        output in_data,
        output wr_fifo_full,
        input  in_ready,
        input  write_apps_data,
        input  wr_data
    );
endinterface

// File: rtl/rah_result_packetizer.sv
// ----------------------------------------------------------------------------
// rah_result_packetizer
// Accepts one wide result per valid/ready handshake and serializes it into a
// framed burst for the rah_encoder write FIFO:
//   header  {MAGIC, APP_ID, seq_num, NUM_WORDS[15:0]}
//   payload NUM_WORDS words, MSB first, last word zero-padded in its LSBs
//   trailer XOR of all payload words
// Writes are throttled by wr_fifo_full; nothing advances on a stalled cycle.
//
// Ports:
//   clk       single clock (encoder write domain)
//   rst       synchronous active-high reset
//   bus       result handshake + encoder FIFO write port (master modport)
//   busy      packet in progress
//   pkt_done  one-cycle pulse coinciding with the trailer write
//   seq_num   sequence number of the next packet
// ----------------------------------------------------------------------------
module rah_result_packetizer #(
    parameter int unsigned RAH_PACKET_WIDTH = 48,
    parameter int unsigned PAYLOAD_WIDTH    = 288,
    parameter logic [7:0]  APP_ID           = 8'd1,
    parameter logic [7:0]  MAGIC            = 8'h5A,
    // Reset value of seq_num
    parameter logic [15:0] SEQ_INIT         = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst,
    rah_result_packetizer_if.master bus,
    output logic                   busy,
    output logic                   pkt_done,
    output logic [15:0]            seq_num
);

    localparam int unsigned NUM_WORDS =
        (PAYLOAD_WIDTH + RAH_PACKET_WIDTH - 1) / RAH_PACKET_WIDTH;
    localparam int unsigned SHIFT_W   = NUM_WORDS * RAH_PACKET_WIDTH;
    localparam int unsigned CNT_W     = $clog2(NUM_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_WORDS - 1);
    localparam logic [15:0]      LEN_FIELD = 16'(NUM_WORDS);

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
        StPayload,
        StTrailer
    } state_e;

    state_e                      r_state, w_state_nxt;
    logic [SHIFT_W-1:0]          r_shift, w_shift_nxt;
    logic [SHIFT_W-1:0]          w_padded;
    logic [RAH_PACKET_WIDTH-1:0] r_csum, w_csum_nxt;
    logic [RAH_PACKET_WIDTH-1:0] r_word, w_word_nxt;
    logic [RAH_PACKET_WIDTH-1:0] w_top;
    logic [RAH_PACKET_WIDTH-1:0] w_header;
    logic [CNT_W-1:0]            r_cnt, w_cnt_nxt;
    logic [15:0]                 r_seq, w_seq_nxt;
    logic                        w_write;

    // Left-justify the payload; unused LSBs of the last word stay zero.
    always_comb begin
        w_padded = '0;
        w_padded[SHIFT_W-1 -: PAYLOAD_WIDTH] = bus.in_data;
    end

    assign w_top    = r_shift[SHIFT_W-1 -: RAH_PACKET_WIDTH];
    assign w_header = RAH_PACKET_WIDTH'({MAGIC, APP_ID, r_seq, LEN_FIELD});

    // rst gates the strobe so an abandoned packet never leaks a word.
    assign w_write  = (r_state != StIdle) && !bus.wr_fifo_full && !rst;

    // r_word always holds the word of the current state, so each transition
    // preloads the word of the state being entered.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_csum_nxt  = r_csum;
        w_word_nxt  = r_word;
        w_cnt_nxt   = r_cnt;
        w_seq_nxt   = r_seq;
        unique case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_shift_nxt = w_padded;
                    w_csum_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_word_nxt  = w_header;
                    w_state_nxt = StHeader;
                end
            end
            StHeader: begin
                if (w_write) begin
                    w_word_nxt  = w_top;
                    w_state_nxt = StPayload;
                end
            end
            StPayload: begin
                if (w_write) begin
                    w_shift_nxt = r_shift << RAH_PACKET_WIDTH;
                    w_csum_nxt  = r_csum ^ w_top;
                    w_cnt_nxt   = r_cnt + 1'b1;
                    if (r_cnt == LAST_IDX) begin
                        w_word_nxt  = r_csum ^ w_top;
                        w_state_nxt = StTrailer;
                    end else begin
                        w_word_nxt  = w_shift_nxt[SHIFT_W-1 -: RAH_PACKET_WIDTH];
                    end
                end
            end
            StTrailer: begin
                if (w_write) begin
                    w_word_nxt  = '0;
                    w_seq_nxt   = r_seq + 16'd1;
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_shift <= '0;
            r_csum  <= '0;
            r_word  <= '0;
            r_cnt   <= '0;
            r_seq   <= SEQ_INIT;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_csum  <= w_csum_nxt;
            r_word  <= w_word_nxt;
            r_cnt   <= w_cnt_nxt;
            r_seq   <= w_seq_nxt;
        end
    end

    assign bus.in_ready        = (r_state == StIdle);
    assign bus.write_apps_data = w_write;
    assign bus.wr_data         = r_word;
    assign busy                = (r_state != StIdle);
    assign pkt_done            = w_write && (r_state == StTrailer);
    assign seq_num             = r_seq;

endmodule
